video_pattern_tx: RTL

//  Video source for the edge-detection core input bus. Generates raster timing
//  (HSYNC/VSYNC/DE) and a pixel clock, and drives a 24-bit test pattern.
//  The output bus is pin-compatible with the core's I_PIX_DATA/I_VSYNC/I_HSYNC/I_DE/I_PCLK.

---
 rtl/video_pattern_tx.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/video_pattern_tx.sv
// ---------------------------------------------------------------------------
// video_pattern_tx
//
// Raster video source for the edge-detection core input bus. Produces the
// pixel clock, HSYNC/VSYNC/DE timing and a 24-bit test pattern. It serves
// both as on-chip BIST stimulus and as a bench driver.
//
// The pixel clock is I_CORE_CLK/2. Every registered output other than O_PCLK
// changes only on the core clock edge where the phase bit falls from 1 to 0,
// so data always changes on the falling edge of O_PCLK and is stable for the
// sink's rising-edge sample.
//
// Ports
//   I_CORE_CLK     in   1   single clock; pixel rate = I_CORE_CLK/2
//   I_RST          in   1   asynchronous, active-high reset
//   I_EN           in   1   run request, honoured only at frame boundaries
//   I_PATTERN      in   2   0 solid, 1 colour bars, 2 gradient, 3 checkerboard
//   I_SOLID        in   24  colour for the solid pattern, {R,G,B}
//   O_PIX_DATA     out  24  pixel {R[23:16],G[15:8],B[7:0]}, zero outside DE
//   O_VSYNC        out  1   vertical sync, asserted level VS_POL
//   O_HSYNC        out  1   horizontal sync, asserted level HS_POL
//   O_DE           out  1   data enable, high in the active area
//   O_PCLK         out  1   pixel clock
//   O_FRAME_START  out  1   high for the pixel period of pixel (0,0)
// ---------------------------------------------------------------------------
module video_pattern_tx #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0
) (
   input  logic        I_CORE_CLK,
   input  logic        I_RST,
   input  logic        I_EN,
   input  logic [1:0]  I_PATTERN,
   input  logic [23:0] I_SOLID,
   output logic [23:0] O_PIX_DATA,
   output logic        O_VSYNC,
   output logic        O_HSYNC,
   output logic        O_DE,
   output logic        O_PCLK,
   output logic        O_FRAME_START
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_W     = $clog2(H_TOTAL);
   localparam int V_W     = $clog2(V_TOTAL);
   localparam int BAR_LEN = H_ACTIVE / 8;
   localparam int BAR_W   = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1;

   localparam logic [H_W-1:0]   H_LAST     = H_W'(H_TOTAL - 1);
   localparam logic [H_W-1:0]   H_ACT_END  = H_W'(H_ACTIVE);
   localparam logic [H_W-1:0]   H_SYNC_BEG = H_W'(H_ACTIVE + H_FP);
   localparam logic [H_W-1:0]   H_SYNC_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [V_W-1:0]   V_LAST     = V_W'(V_TOTAL - 1);
   localparam logic [V_W-1:0]   V_ACT_END  = V_W'(V_ACTIVE);
   localparam logic [V_W-1:0]   V_SYNC_BEG = V_W'(V_ACTIVE + V_FP);
   localparam logic [V_W-1:0]   V_SYNC_END = V_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [BAR_W-1:0] BAR_LAST   = BAR_W'(BAR_LEN - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t           r_state;
   logic             r_phase;
   logic [H_W-1:0]   r_h;
   logic [V_W-1:0]   r_v;
   logic [2:0]       r_barIdx;
   logic [BAR_W-1:0] r_barPix;
   logic [1:0]       r_pattern;
   logic [23:0]      r_solid;
   logic [23:0]      r_pix;
   logic             r_de;
   logic             r_hsync;
   logic             r_vsync;
   logic             r_frameStart;

   state_t           w_stateNext;
   logic [H_W-1:0]   w_hNext;
   logic [V_W-1:0]   w_vNext;
   logic [2:0]       w_barIdxNext;
   logic [BAR_W-1:0] w_barPixNext;
   logic [1:0]       w_patternNext;
   logic [23:0]      w_solidNext;
   logic             w_frameStartNext;
   logic [23:0]      w_barColour;
   logic [7:0]       w_x;
   logic [7:0]       w_y;
   logic             w_run;
   logic [23:0]      w_pixNext;
   logic             w_deNext;
   logic             w_hsyncNext;
   logic             w_vsyncNext;

   // Frame sequencer: decides which pixel position is presented after the
   // next update edge. The pattern selection and solid colour are captured
   // only when a frame begins, and I_EN is looked at only when idle or on
   // the last pixel of a frame, so frames are always emitted whole.
   always_comb begin
      w_stateNext      = r_state;
      w_hNext          = r_h;
      w_vNext          = r_v;
      w_patternNext    = r_pattern;
      w_solidNext      = r_solid;
      w_frameStartNext = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (I_EN) begin
               w_stateNext      = ST_RUN;
               w_hNext          = '0;
               w_vNext          = '0;
               w_patternNext    = I_PATTERN;
               w_solidNext      = I_SOLID;
               w_frameStartNext = 1'b1;
            end
         end
         ST_RUN: begin
            if (r_h == H_LAST) begin
               w_hNext = '0;
               if (r_v == V_LAST) begin
                  w_vNext = '0;
                  if (I_EN) begin
                     w_patternNext    = I_PATTERN;
                     w_solidNext      = I_SOLID;
                     w_frameStartNext = 1'b1;
                  end else begin
                     w_stateNext = ST_IDLE;
                  end
               end else begin
                  w_vNext = r_v + 1'b1;
               end
            end else begin
               w_hNext = r_h + 1'b1;
            end
         end
         default: begin
            w_stateNext = ST_IDLE;
            w_hNext     = '0;
            w_vNext     = '0;
         end
      endcase
   end

   // Colour-bar tracking without a divider: r_barPix counts pixels inside
   // the current bar and r_barIdx steps to the next bar each time a full
   // bar width has gone by. Both restart whenever a line restarts at h=0,
   // which also covers the idle state where h is held at zero.
   always_comb begin
      w_barIdxNext = r_barIdx;
      w_barPixNext = r_barPix;
      if (w_hNext == '0) begin
         w_barIdxNext = '0;
         w_barPixNext = '0;
      end else if (r_barPix == BAR_LAST) begin
         w_barIdxNext = r_barIdx + 1'b1;
         w_barPixNext = '0;
      end else begin
         w_barPixNext = r_barPix + 1'b1;
      end
   end

   // Colour lookup for the bar that the next pixel belongs to.
   always_comb begin
      w_barColour = 24'h000000;
      case (w_barIdxNext)
         3'd0:    w_barColour = 24'hFFFFFF;
         3'd1:    w_barColour = 24'hFFFF00;
         3'd2:    w_barColour = 24'h00FFFF;
         3'd3:    w_barColour = 24'h00FF00;
         3'd4:    w_barColour = 24'hFF00FF;
         3'd5:    w_barColour = 24'hFF0000;
         3'd6:    w_barColour = 24'h0000FF;
         default: w_barColour = 24'h000000;
      endcase
   end

   // Output decode for the upcoming pixel. Everything is derived from the
   // next position so that the registered outputs line up exactly with the
   // (h,v) they describe. Outside RUN all outputs take their idle levels.
   always_comb begin
      w_x         = 8'(w_hNext);
      w_y         = 8'(w_vNext);
      w_run       = (w_stateNext == ST_RUN);
      w_deNext    = w_run && (w_hNext < H_ACT_END) && (w_vNext < V_ACT_END);
      w_hsyncNext = ~HS_POL;
      w_vsyncNext = ~VS_POL;
      if (w_run && (w_hNext >= H_SYNC_BEG) && (w_hNext < H_SYNC_END)) begin
         w_hsyncNext = HS_POL;
      end
      if (w_run && (w_vNext >= V_SYNC_BEG) && (w_vNext < V_SYNC_END)) begin
         w_vsyncNext = VS_POL;
      end
      w_pixNext = 24'h000000;
      if (w_deNext) begin
         case (w_patternNext)
            2'd0:    w_pixNext = w_solidNext;
            2'd1:    w_pixNext = w_barColour;
            2'd2:    w_pixNext = {w_x, w_y, w_x ^ w_y};
            default: w_pixNext = (w_x[3] ^ w_y[3]) ? 24'hFFFFFF : 24'h000000;
         endcase
      end
   end

   // State and output registers. The phase bit runs on every core clock and
   // is the pixel clock itself; everything else is loaded only on the edge
   // where the phase falls, i.e. once per pixel period.
   always_ff @(posedge I_CORE_CLK or posedge I_RST) begin
      if (I_RST) begin
         r_phase      <= 1'b0;
         r_state      <= ST_IDLE;
         r_h          <= '0;
         r_v          <= '0;
         r_barIdx     <= '0;
         r_barPix     <= '0;
         r_pattern    <= 2'd0;
         r_solid      <= 24'h000000;
         r_pix        <= 24'h000000;
         r_de         <= 1'b0;
         r_hsync      <= ~HS_POL;
         r_vsync      <= ~VS_POL;
         r_frameStart <= 1'b0;
      end else begin
         r_phase <= ~r_phase;
         if (r_phase) begin
            r_state      <= w_stateNext;
            r_h          <= w_hNext;
            r_v          <= w_vNext;
            r_barIdx     <= w_barIdxNext;
            r_barPix     <= w_barPixNext;
            r_pattern    <= w_patternNext;
            r_solid      <= w_solidNext;
            r_pix        <= w_pixNext;
            r_de         <= w_deNext;
            r_hsync      <= w_hsyncNext;
            r_vsync      <= w_vsyncNext;
            r_frameStart <= w_frameStartNext;
         end
      end
   end

   assign O_PCLK        = r_phase;
   assign O_PIX_DATA    = r_pix;
   assign O_DE          = r_de;
   assign O_HSYNC       = r_hsync;
   assign O_VSYNC       = r_vsync;
   assign O_FRAME_START = r_frameStart;

endmodule
